// File: rtl/hex_word_parser_pkg.sv
// Shared types and constants for the hex word parser: FSM states,
// delimiter characters, error codes and a delimiter classifier.
package hex_word_parser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic [7:0] DLM_SP    = 8'h20;
    localparam logic [7:0] DLM_COMMA = 8'h2C;
    localparam logic [7:0] DLM_CR    = 8'h0D;
    localparam logic [7:0] DLM_LF    = 8'h0A;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_INVALID  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;

    // True when the character terminates a token.
    function automatic logic is_delimiter(input logic [7:0] c);
        return (c == DLM_SP) || (c == DLM_COMMA) || (c == DLM_CR) || (c == DLM_LF);
    endfunction

endpackage

// File: rtl/hex_word_parser_if.sv
// Character-in / word-out bus of the hex word parser.
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high; the source holds data stable
// while valid is high and ready is low, and ready never depends
// combinationally on valid.
interface hex_word_parser_if #(
    parameter int WIDTH = 32
);
    localparam int NMAX  = WIDTH / 4;
    localparam int NIB_W = $clog2(NMAX + 1);

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready;
    logic [NIB_W-1:0] nib_cnt;
    logic             err_flg;
    logic [1:0]       err_code;

    // Character source / word consumer side.
    modport master (
        output rx_data, rx_valid, word_ready,
        input  rx_ready, word, word_valid, nib_cnt, err_flg, err_code
    );

    // Parser side.
    modport slave (
        input  rx_data, rx_valid, word_ready,
        output rx_ready, word, word_valid, nib_cnt, err_flg, err_code
    );
endinterface

// File: rtl/hex_word_parser_dc_ascii_hex.sv
// ASCII to hex nibble decoder: flags 0-9, A-F, a-f and returns the value.
module DC_ASCII_HEX (
    input  logic [7:0] i_ascii,
    output logic [3:0] o_hex,
    output logic       o_hex_flg
);

    // Range-classify the character and derive the nibble value.
    always_comb begin
        o_hex     = 4'd0;
        o_hex_flg = 1'b0;
        if (i_ascii >= 8'h30 && i_ascii <= 8'h39) begin
            o_hex     = i_ascii[3:0];
            o_hex_flg = 1'b1;
        end else if ((i_ascii >= 8'h41 && i_ascii <= 8'h46) ||
                     (i_ascii >= 8'h61 && i_ascii <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
            o_hex     = i_ascii[3:0] + 4'd9;
            o_hex_flg = 1'b1;
        end
    end

endmodule

// File: rtl/hex_word_parser.sv
// Hex word parser: assembles hex digits from an ASCII stream into a word,
// emits it on a delimiter, and flags invalid characters or overflow.
module hex_word_parser
    import hex_word_parser_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    hex_word_parser_if.slave bus,
    output state_t           o_state
);

    localparam int NMAX  = WIDTH / 4;
    localparam int NIB_W = $clog2(NMAX + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_word;
    logic [NIB_W-1:0] r_nib_cnt;
    logic             r_err_flg;
    logic [1:0]       r_err_code;

    logic [3:0]       w_hex;
    logic             w_hex_flg;
    logic             w_is_dlm;
    logic             w_accept;
    logic             w_load_first;
    logic             w_shift;
    logic             w_clear;
    logic             w_err_set;
    logic [1:0]       w_err_code_nxt;
    logic [WIDTH-1:0] w_digit_ext;

    DC_ASCII_HEX u_dec (
        .i_ascii   (bus.rx_data),
        .o_hex     (w_hex),
        .o_hex_flg (w_hex_flg)
    );

    assign w_is_dlm = is_delimiter(bus.rx_data);

    // Ready/valid come from the registered state only.
    assign bus.rx_ready   = (r_state != ST_DONE);
    assign bus.word_valid = (r_state == ST_DONE);
    assign w_accept       = bus.rx_valid && bus.rx_ready;

    assign bus.word     = r_word;
    assign bus.nib_cnt  = r_nib_cnt;
    assign bus.err_flg  = r_err_flg;
    assign bus.err_code = r_err_code;
    assign o_state      = r_state;

    // Zero-extend the decoded nibble to word width (also valid for WIDTH=4).
    always_comb begin
        w_digit_ext      = '0;
        w_digit_ext[3:0] = w_hex;
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_load_first   = 1'b0;
        w_shift        = 1'b0;
        w_clear        = 1'b0;
        w_err_set      = 1'b0;
        w_err_code_nxt = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_hex_flg) begin
                        w_load_first = 1'b1;
                        w_state_nxt  = ST_ACCUM;
                    end else if (!w_is_dlm) begin
                        w_err_set      = 1'b1;
                        w_err_code_nxt = ERR_INVALID;
                        w_state_nxt    = ST_ERR;
                    end
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    if (w_hex_flg) begin
                        if (r_nib_cnt == NIB_W'(NMAX)) begin
                            w_err_set      = 1'b1;
                            w_err_code_nxt = ERR_OVERFLOW;
                            w_state_nxt    = ST_ERR;
                        end else begin
                            w_shift = 1'b1;
                        end
                    end else if (w_is_dlm) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_err_set      = 1'b1;
                        w_err_code_nxt = ERR_INVALID;
                        w_state_nxt    = ST_ERR;
                    end
                end
            end
            ST_DONE: begin
                if (bus.word_ready) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                // Discard everything until a delimiter resynchronises.
                if (w_accept && w_is_dlm) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Word, digit count and error reporting registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word     <= '0;
            r_nib_cnt  <= '0;
            r_err_flg  <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_err_flg <= 1'b0;
            if (w_err_set) begin
                r_word     <= '0;
                r_nib_cnt  <= '0;
                r_err_flg  <= 1'b1;
                r_err_code <= w_err_code_nxt;
            end else if (w_load_first) begin
                r_word    <= w_digit_ext;
                r_nib_cnt <= NIB_W'(1);
            end else if (w_shift) begin
                r_word    <= (r_word << 4) | w_digit_ext;
                r_nib_cnt <= r_nib_cnt + NIB_W'(1);
            end else if (w_clear) begin
                r_word    <= '0;
                r_nib_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/hex_word_parser.md
# hex_word_parser

Stream controller that sequences the ASCII-to-hex decoder (`DC_ASCII_HEX`) over an incoming byte stream. It accepts ASCII characters over a valid/ready handshake and assembles consecutive hex digits into one WIDTH-bit word. A delimiter emits the word on an output valid/ready handshake. It sits between a UART/console receive path and command/register-access logic, and reports malformed tokens with an error pulse and code.

## Interface
- `WIDTH`, default 32: output word width in bits; multiple of 4, ≥4. `NMAX` = WIDTH/4 digits.
- `CLK`  in  1: clock; all state changes on the rising edge.
- `RST`  in  1: reset, asynchronous and active-high.
- `RX_DATA`  in  8: ASCII character.
- `RX_VALID`  in  1: `RX_DATA` valid.
- `RX_READY`  out  1: parser accepts a character this cycle.
- `WORD`  out  WIDTH: assembled value, right-aligned, zero-extended.
- `WORD_VALID`  out  1: `WORD` valid; held until accepted.
- `WORD_READY`  in  1: consumer accepts `WORD`.
- `NIB_CNT`  out  $clog2(NMAX+1): digits in current token.
- `ERR_FLG`  out  1: one-cycle pulse on token error.
- `ERR_CODE`  out  2: last error. 0 = none, 1 = invalid char, 2 = overflow (more than NMAX digits).

## Operation
- Accept: a character is consumed only on `RX_VALID && RX_READY`.
- Classification is done by the decoder on `RX_DATA`:
  - hex digit: `0-9`, `A-F`, `a-f`.
  - delimiter: 0x20, 0x2C, 0x0D, 0x0A.
  - invalid: anything else.
- States: IDLE, ACCUM, DONE, ERR.
- IDLE, `RX_READY` = 1:
  - hex digit → `WORD` = digit, `NIB_CNT` = 1, go to ACCUM.
  - delimiter → discarded, stay in IDLE. No empty words are emitted.
  - invalid → go to ERR with code 1.
- ACCUM, `RX_READY` = 1:
  - hex digit with `NIB_CNT` < NMAX → `WORD` = {`WORD`[WIDTH-5:0], digit}, `NIB_CNT`+1.
  - hex digit with `NIB_CNT` = NMAX → go to ERR with code 2.
  - delimiter → go to DONE.
  - invalid → go to ERR with code 1.
- DONE, `RX_READY` = 0, `WORD_VALID` = 1:
  - on `WORD_READY` → go to IDLE; `WORD` and `NIB_CNT` are cleared.
- ERR, `RX_READY` = 1:
  - entering ERR pulses `ERR_FLG` for one cycle, loads `ERR_CODE`, and clears `WORD`/`NIB_CNT`.
  - all characters are discarded until a delimiter is accepted, then go to IDLE (resync).
  - further invalid characters while in ERR raise no additional pulses.
- `ERR_CODE` holds its value until the next error or reset. It is never cleared by a successful word.
- Reset, at any point including mid-token or with `WORD_VALID` high:
  - state = IDLE.
  - `WORD` = 0, `NIB_CNT` = 0, `WORD_VALID` = 0, `ERR_FLG` = 0, `ERR_CODE` = 0.
  - `RX_READY` = 1 immediately after reset deasserts.

## Timing
- `RX_READY` and `WORD_VALID` are decoded from the registered state only. No combinational path runs from `RX_VALID`/`WORD_READY` to them.
- Throughput is one character per cycle in IDLE/ACCUM/ERR.
- Latency: delimiter accepted at edge N → `WORD_VALID` = 1 after edge N, with `WORD` stable.
- Word handshake:
  - if `WORD_READY` is already high in that cycle, the transfer completes at edge N+1 and `RX_READY` = 1 after N+1.
  - minimum token-to-token gap is one cycle of `RX_READY` = 0.
- `ERR_FLG` is high for exactly the cycle after the edge that accepted the offending character.
- `WORD` and `NIB_CNT` update only on accepted characters or reset, never while stalled.

## Structure
- Package `hex_word_parser_pkg`:
  - state enum {IDLE, ACCUM, DONE, ERR}.
  - delimiter constants (`DLM_SP` 0x20, `DLM_COMMA` 0x2C, `DLM_CR` 0x0D, `DLM_LF` 0x0A).
  - error codes `ERR_NONE`, `ERR_INVALID`, `ERR_OVERFLOW`.
- Sub-module: one instance of `DC_ASCII_HEX` on `RX_DATA`.
  - its `HEX`/`HEX_FLG` drive digit detection.
  - delimiter compare is local.
- Estimated size: one FSM process plus one datapath register process, roughly 150–200 lines.

## Test plan
- "1a2B\r" streamed back-to-back, `WORD_READY` = 1, WIDTH=32 → `WORD` = 0x00001A2B, `NIB_CNT` = 4, `WORD_VALID` one cycle after the CR is accepted, no `ERR_FLG`.
- "DEADBEEF " with `WORD_READY` = 0 for 5 cycles → `WORD_VALID` held with `WORD` = 0xDEADBEEF and `RX_READY` = 0 throughout; released on `WORD_READY`; next token "7\n" → `WORD` = 0x7.
- "123456789 " at WIDTH=32 → `ERR_FLG` pulse after the 9th digit, `ERR_CODE` = 2, no word emitted; a following "5 " → `WORD` = 0x5, `ERR_CODE` still 2.
- "12G4,FF," → `ERR_FLG` pulse on 'G', `ERR_CODE` = 1, '4' discarded, resync at ',', then `WORD` = 0xFF.
- "   ,\r\n" only → no `WORD_VALID`, no `ERR_FLG`, state stays IDLE.
- `RST` asserted asynchronously mid-"AB" and again while `WORD_VALID` = 1 → all outputs 0 and `RX_READY` = 1 after release; "C " → `WORD` = 0xC.
